// File: rtl/t_ff_mon_pkg.sv
// Shared types and defaults for the T flip-flop monitors.
package t_ff_mon_pkg;

   localparam int CNT_W_DEF = 8;
   localparam int PER_W_DEF = 16;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   // Toggle record at the default widths.
   typedef struct packed {
      logic [CNT_W_DEF-1:0] count;
      logic [PER_W_DEF-1:0] period;
      logic                 level;
      logic                 lost;
   } mon_rec_t;

endpackage

// File: rtl/t_ff_toggle_monitor_edge_det.sv
// Edge detector on a signal that is already synchronous to clk.
module edge_det (
   input  logic clk,
   input  logic rst,
   input  logic q_in,
   output logic toggle,
   output logic level
);

   logic q_d;

   // Delayed copy of q_in. It resets to 0, so an input held high through reset
   // shows up as a rising toggle on the first cycle after release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) q_d <= 1'b0;
      else     q_d <= q_in;
   end

   assign toggle = q_in ^ q_d;
   assign level  = q_in;

endmodule

// File: rtl/t_ff_toggle_monitor.sv
// Monitors a T flip-flop Q: counts toggles, measures the period between them,
// and offers one record per toggle on a valid/ready port, dropping on overflow.
module t_ff_toggle_monitor
   import t_ff_mon_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int PER_W = PER_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             q_in,
   input  logic             clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] out_count,
   output logic [PER_W-1:0] out_period,
   output logic             out_level,
   output logic             out_lost,
   output logic [CNT_W-1:0] toggle_cnt
);

   // Same layout as mon_rec_t, sized to this instance's parameters.
   typedef struct packed {
      logic [CNT_W-1:0] count;
      logic [PER_W-1:0] period;
      logic             level;
      logic             lost;
   } rec_t;

   logic             toggle;
   logic             level;
   state_e           state_q, state_d;
   logic             load, drop;
   logic [PER_W-1:0] per_cnt, per_next;
   logic [CNT_W-1:0] cnt_next;
   logic             lost_r;
   rec_t             rec_q;

   edge_det u_edge (
      .clk    (clk),
      .rst    (rst),
      .q_in   (q_in),
      .toggle (toggle),
      .level  (level)
   );

   // Saturating increment doubles as the captured period (per_cnt+1, clamped).
   assign per_next = (per_cnt == '1) ? per_cnt : per_cnt + PER_W'(1);
   assign cnt_next = toggle_cnt + CNT_W'(1);

   // Output-slot state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_EMPTY;
      else     state_q <= state_d;
   end

   // Next state plus load/drop decisions; clr overrides toggles and handshakes.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      drop    = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (toggle) begin
               load    = 1'b1;
               state_d = ST_FULL;
            end
         end
         ST_FULL: begin
            if (toggle) begin
               if (out_ready) load = 1'b1;
               else           drop = 1'b1;
            end else if (out_ready) begin
               state_d = ST_EMPTY;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      if (clr) begin
         state_d = ST_EMPTY;
         load    = 1'b0;
         drop    = 1'b0;
      end
   end

   // Toggle and period counters keep running even when a record is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         toggle_cnt <= '0;
         per_cnt    <= '0;
      end else if (clr) begin
         toggle_cnt <= '0;
         per_cnt    <= '0;
      end else if (toggle) begin
         toggle_cnt <= cnt_next;
         per_cnt    <= '0;
      end else begin
         per_cnt    <= per_next;
      end
   end

   // Record register and sticky lost flag; load and drop are mutually exclusive.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rec_q  <= '0;
         lost_r <= 1'b0;
      end else if (clr) begin
         lost_r <= 1'b0;
      end else if (load) begin
         rec_q  <= '{count: cnt_next, period: per_next, level: level, lost: lost_r};
         lost_r <= 1'b0;
      end else if (drop) begin
         lost_r <= 1'b1;
      end
   end

   assign out_valid  = (state_q == ST_FULL);
   assign out_count  = rec_q.count;
   assign out_period = rec_q.period;
   assign out_level  = rec_q.level;
   assign out_lost   = rec_q.lost;

endmodule

// File: tb/tb_t_ff_toggle_monitor.sv
// Randomised plus directed bench for t_ff_toggle_monitor with a behavioural model.
module tb_t_ff_toggle_monitor;

   localparam int CNT_W = 3;
   localparam int PER_W = 8;
   localparam int CMOD  = 1 << CNT_W;
   localparam int PMAX  = (1 << PER_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             q_in = 1'b0;
   logic             clr = 1'b0;
   logic             out_ready = 1'b0;
   logic             out_valid;
   logic [CNT_W-1:0] out_count;
   logic [PER_W-1:0] out_period;
   logic             out_level;
   logic             out_lost;
   logic [CNT_W-1:0] toggle_cnt;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   t_ff_toggle_monitor #(.CNT_W(CNT_W), .PER_W(PER_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .q_in       (q_in),
      .clr        (clr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_count  (out_count),
      .out_period (out_period),
      .out_level  (out_level),
      .out_lost   (out_lost),
      .toggle_cnt (toggle_cnt)
   );

   always #5 clk = ~clk;

   // Model: counts of toggles and of cycles since the last toggle, plus a
   // one-entry output slot that keeps its record until the consumer takes it.
   int m_cnt = 0, m_since = 0, e_count = 0, e_period = 0;
   bit m_prev = 0, m_valid = 0, m_lost = 0, e_level = 0, e_lost = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_prev <= 0; m_cnt <= 0; m_since <= 0; m_valid <= 0; m_lost <= 0;
         e_count <= 0; e_period <= 0; e_level <= 0; e_lost <= 0;
      end else begin
         automatic bit tog = (q_in != m_prev);
         m_prev <= q_in;
         if (clr) begin
            m_cnt <= 0; m_since <= 0; m_lost <= 0; m_valid <= 0;
         end else if (tog) begin
            automatic int c = (m_cnt + 1) % CMOD;
            automatic int p = (m_since + 1 > PMAX) ? PMAX : m_since + 1;
            m_cnt <= c; m_since <= 0;
            if (!m_valid || out_ready) begin
               m_valid <= 1; e_count <= c; e_period <= p;
               e_level <= q_in; e_lost <= m_lost; m_lost <= 0;
            end else begin
               m_lost <= 1;
            end
         end else begin
            m_since <= (m_since + 1 > PMAX) ? PMAX : m_since + 1;
            if (m_valid && out_ready) m_valid <= 0;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Compare DUT against the model every cycle, away from the active edge.
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         chk("valid", out_valid, m_valid);
         chk("toggle_cnt", toggle_cnt, m_cnt);
         if (m_valid) begin
            chk("count", out_count, e_count);
            chk("period", out_period, e_period);
            chk("level", out_level, e_level);
            chk("lost", out_lost, e_lost);
         end
      end
   end

   // Apply one cycle of inputs; returns 2 time units after the edge.
   task automatic step(input bit q, input bit r, input bit c);
      q_in = q; out_ready = r; clr = c;
      @(posedge clk); #2;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      chk("rst_valid", out_valid, 0);
      chk("rst_count", out_count, 0);
      chk("rst_period", out_period, 0);
      chk("rst_level", out_level, 0);
      chk("rst_lost", out_lost, 0);
      chk("rst_tcnt", toggle_cnt, 0);
      chk_en = 1'b1;

      // Toggle every cycle with the consumer always ready.
      step(0, 1, 0); step(0, 1, 0);
      step(1, 1, 0);
      chk("t1_count", out_count, 1); chk("t1_period", out_period, 3); chk("t1_level", out_level, 1);
      step(0, 1, 0);
      chk("t2_count", out_count, 2); chk("t2_period", out_period, 1); chk("t2_level", out_level, 0);
      step(1, 1, 0);
      chk("t3_count", out_count, 3); chk("t3_level", out_level, 1);
      step(0, 1, 0);
      chk("t4_count", out_count, 4); chk("t4_period", out_period, 1); chk("t4_level", out_level, 0);
      step(0, 1, 0);
      chk("t4_drain", out_valid, 0);

      // Back-pressure: first record held, two drops, then lost flag reported once.
      step(0, 0, 1);
      step(1, 0, 0); chk("bp_first", out_count, 1);
      step(0, 0, 0); chk("bp_hold1", out_count, 1);
      step(1, 0, 0); chk("bp_hold2", out_count, 1); chk("bp_valid", out_valid, 1);
      step(0, 1, 0); chk("bp_next", out_count, 4); chk("bp_lost", out_lost, 1);
      step(0, 1, 0); chk("bp_empty", out_valid, 0);
      step(1, 1, 0); chk("bp_after", out_count, 5); chk("bp_lost_clr", out_lost, 0);
      step(1, 1, 0);

      // Period saturation.
      repeat (PMAX + 6) step(1, 1, 0);
      step(0, 1, 0); chk("sat_period", out_period, PMAX);

      // Count wraps at CNT_W bits.
      step(0, 1, 1);
      for (int i = 0; i < 9; i++) begin
         step(~q_in, 1, 0);
         chk("wrap_count", out_count, (i + 1) % CMOD);
      end

      // clr beats a simultaneous toggle and handshake.
      step(~q_in, 1, 0); chk("clr_pre", out_valid, 1);
      step(~q_in, 1, 1); chk("clr_valid", out_valid, 0); chk("clr_tcnt", toggle_cnt, 0);
      step(q_in, 1, 0); step(q_in, 1, 0);
      step(~q_in, 1, 0); chk("clr_count", out_count, 1); chk("clr_period", out_period, 3);

      // Asynchronous reset between edges while FULL.
      step(~q_in, 0, 0); chk("ar_pre", out_valid, 1);
      #1 rst = 1'b1;
      #1;
      chk("ar_valid", out_valid, 0); chk("ar_count", out_count, 0);
      chk("ar_period", out_period, 0); chk("ar_level", out_level, 0);
      chk("ar_lost", out_lost, 0); chk("ar_tcnt", toggle_cnt, 0);
      q_in = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;

      // Random traffic.
      for (int i = 0; i < 2000; i++)
         step($urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
